// File: rtl/pf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pf_ctrl_pkg
// Shared definitions for the pipeline power-up / reload control blocks.
//   ST_IDLE/ST_LOAD/ST_FLUSH/ST_RUN : 2-bit state encodings, visible on the
//                                     sequencer's state output
//   WORD_BYTES                      : bytes per instruction word; a loaded
//                                     image must be a whole number of words
//   state_t                         : enum view of the same encodings
//   last_of_word()                  : true when the byte about to be accepted
//                                     completes a word
// ---------------------------------------------------------------------------
package pf_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;
  localparam logic [1:0] ST_RUN   = 2'b11;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_FLUSH = ST_FLUSH,
    S_RUN   = ST_RUN
  } state_t;

  // (count + 1) % WORD_BYTES == 0, evaluated on the low bits of the count of
  // bytes accepted so far. WORD_BYTES is a power of two, so two bits suffice.
  function automatic logic last_of_word(input logic [1:0] count_lsb);
    return count_lsb == 2'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/boot_load_sequencer_flush_counter.sv
// ---------------------------------------------------------------------------
// flush_counter
// Down-counter that measures a fixed window of FLUSH_CYCLES clock cycles,
// reusable for flush or stall windows.
//   clk   in  : clock, rising edge
//   rst_n in  : synchronous reset, active-low; count returns to 0
//   load  in  : start a window (count <= FLUSH_CYCLES-1)
//   en    in  : count down while the window is open
//   zero  out : count is 0; the current cycle is the last of the window
// With load on the entry edge and en held, zero is first seen FLUSH_CYCLES-1
// cycles later, so the owner spends exactly FLUSH_CYCLES cycles in the window.
// ---------------------------------------------------------------------------
module flush_counter #(
  parameter int FLUSH_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(FLUSH_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/boot_load_sequencer.sv
// ---------------------------------------------------------------------------
// boot_load_sequencer
// Power-up / reload controller for the 5-stage pipeline. Holds the pipeline
// in reset while a byte image streams in over valid/ready, writes every byte
// to InstructionMemory and DataMemory at the same address, keeps the pipeline
// in reset for a flush window after the load, then releases it to RUN.
//   Clk        in  : clock, rising edge
//   R          in  : synchronous reset, active-low
//   start      in  : begin a (re)load; honoured in IDLE (incl. error) and RUN
//   byte_in    in  : image byte
//   byte_valid in  : byte_in valid
//   byte_last  in  : final byte of the image
//   byte_ready out : byte accepted this cycle (pure decode of LOAD)
//   mem_we     out : registered write strobe, one cycle after a transfer
//   mem_addr   out : registered write byte address
//   mem_wdata  out : registered write data
//   pipe_reset out : registered active-high pipeline reset
//   pipe_le    out : registered IF/ID load enable, 1 only in RUN
//   state      out : 00 IDLE, 01 LOAD, 10 FLUSH, 11 RUN
//   err        out : sticky overflow / misaligned-length flag
//   byte_count out : bytes accepted in the current load
// ---------------------------------------------------------------------------
module boot_load_sequencer
  import pf_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int MEM_BYTES    = 256,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              pipe_reset,
  output logic              pipe_le,
  output logic [1:0]        state,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  state_t            st, st_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              xfer;
  logic              clr_load;
  logic              err_set;
  logic              fc_load;
  logic              fc_zero;

  assign byte_ready = (st == S_LOAD);
  assign xfer       = byte_valid & byte_ready;
  assign state      = st;

  flush_counter #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_counter (
    .clk   (Clk),
    .rst_n (R),
    .load  (fc_load),
    .en    (st == S_FLUSH),
    .zero  (fc_zero)
  );

  // Next-state decode. A last byte on the top address is a normal end of
  // image, so byte_last is tested before the overflow address.
  always_comb begin
    st_nxt   = st;
    clr_load = 1'b0;
    err_set  = 1'b0;
    fc_load  = 1'b0;
    case (st)
      S_IDLE, S_RUN: begin
        if (start) begin
          st_nxt   = S_LOAD;
          clr_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (byte_last) begin
            if (last_of_word(byte_count[1:0])) begin
              st_nxt  = S_FLUSH;
              fc_load = 1'b1;
            end else begin
              st_nxt  = S_IDLE;
              err_set = 1'b1;
            end
          end else if (wr_addr == ADDR_W'(MEM_BYTES - 1)) begin
            st_nxt  = S_IDLE;
            err_set = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (fc_zero) begin
          st_nxt = S_RUN;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // pipe_reset/pipe_le are decoded from the next state so they change on the
  // same edge as state itself.
  always_ff @(posedge Clk) begin
    if (!R) begin
      st         <= S_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_addr    <= '0;
      byte_count <= '0;
      err        <= 1'b0;
      pipe_reset <= 1'b1;
      pipe_le    <= 1'b0;
    end else begin
      st         <= st_nxt;
      pipe_reset <= (st_nxt != S_RUN);
      pipe_le    <= (st_nxt == S_RUN);
      mem_we     <= xfer;
      if (xfer) begin
        mem_addr  <= wr_addr;
        mem_wdata <= byte_in;
      end
      if (clr_load) begin
        wr_addr    <= '0;
        byte_count <= '0;
        err        <= 1'b0;
      end else if (xfer) begin
        wr_addr    <= wr_addr + ADDR_W'(1);
        byte_count <= byte_count + (ADDR_W + 1)'(1);
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule
